// File: rtl/kernel_avmm_mem_pkg.sv
// rtl/kernel_avmm_mem_pkg.sv - shared types, widths and address helper for kernel_avmm_mem
package kernel_avmm_mem_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int BE_W       = DATA_W_DEF / 8;
    localparam int WORD_SHIFT = $clog2(BE_W);

    // One accepted access as it enters the read pipeline
    typedef struct packed {
        logic        valid;
        logic        is_host;
        logic [63:0] word;
        logic        oob;
    } mem_req_t;

    // Byte address to word index; the low (sub-word) bits drop out in the shift
    function automatic logic [63:0] addr_to_word(input logic [63:0] addr,
                                                 input logic [63:0] base,
                                                 input int          shift = WORD_SHIFT);
        return (addr - base) >> shift;
    endfunction

endpackage

// File: rtl/kernel_avmm_mem_ram.sv
// rtl/kernel_avmm_mem_ram.sv - single-port byte-enable RAM with registered read
module kernel_avmm_mem_ram #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = 12
) (
    input  logic                  clk_i,
    input  logic [AW-1:0]         addr_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write and registered read; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/kernel_avmm_mem.sv
// rtl/kernel_avmm_mem.sv - dual-master matrix RAM, kernel priority; KERNEL_AVMM_MEM_PERF_EN adds perf counters
module kernel_avmm_mem
    import kernel_avmm_mem_pkg::*;
#(
    parameter int                ADDR_W       = 64,
    parameter int                DATA_W       = 64,
    parameter int                DEPTH_WORDS  = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [ADDR_W-1:0]     avmm_0_rw_address,
    input  logic [DATA_W/8-1:0]   avmm_0_rw_byteenable,
    input  logic                  avmm_0_rw_read,
    input  logic                  avmm_0_rw_write,
    input  logic [DATA_W-1:0]     avmm_0_rw_writedata,
    output logic [DATA_W-1:0]     avmm_0_rw_readdata,
    input  logic [ADDR_W-1:0]     host_address,
    input  logic [DATA_W/8-1:0]   host_byteenable,
    input  logic                  host_read,
    input  logic                  host_write,
    input  logic [DATA_W-1:0]     host_writedata,
    output logic                  host_waitrequest,
    output logic [DATA_W-1:0]     host_readdata,
    output logic                  host_readdatavalid,
    output logic                  oob_err,
`ifdef KERNEL_AVMM_MEM_PERF_EN
    output logic [31:0]           perf_kreads,
    output logic [31:0]           perf_kwrites,
    output logic [31:0]           perf_host_stalls,
`endif
    output logic                  proto_err
);

    localparam int BEW   = DATA_W / 8;
    localparam int SHIFT = $clog2(BEW);
    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int L     = READ_LATENCY;

    logic                k_act, h_req;
    mem_req_t            sel;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_wr, sel_rw;
    logic [BEW-1:0]      sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   ram_rdata, last_data, stage_data;
    logic [L:1]          pv_q, ph_q, po_q;
    logic [DATA_W-1:0]   krd_q, hrd_q;
    logic                oob_q, proto_q;
    logic                done_k, done_h;

    assign k_act            = avmm_0_rw_read | avmm_0_rw_write;
    assign h_req            = host_read | host_write;
    assign host_waitrequest = h_req & k_act;

    // Pick the single RAM user this cycle: kernel whenever active, otherwise the host
    always_comb begin
        sel       = '0;
        sel_addr  = '0;
        sel_wr    = 1'b0;
        sel_rw    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        if (k_act) begin
            sel.valid = avmm_0_rw_read;
            sel_addr  = avmm_0_rw_address;
            sel_wr    = avmm_0_rw_write;
            sel_rw    = avmm_0_rw_read & avmm_0_rw_write;
            sel_be    = avmm_0_rw_byteenable;
            sel_wdata = avmm_0_rw_writedata;
        end else if (h_req) begin
            sel.valid   = host_read & ~host_write;
            sel.is_host = 1'b1;
            sel_addr    = host_address;
            sel_wr      = host_write;
            sel_be      = host_byteenable;
            sel_wdata   = host_writedata;
        end
        sel.word = addr_to_word(64'(sel_addr), 64'(BASE_ADDR), SHIFT);
        sel.oob  = (k_act | h_req) &
                   ((sel_addr < BASE_ADDR) | (sel.word >= 64'(DEPTH_WORDS)));
    end

    kernel_avmm_mem_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk_i   (clock),
        .addr_i  (sel.word[AW-1:0]),
        .we_i    (sel_wr & ~sel.oob),
        .be_i    (sel_be),
        .wdata_i (sel_wdata),
        .rdata_o (ram_rdata)
    );

    // Request metadata shifts alongside the data; reset flushes reads in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pv_q <= '0;
            ph_q <= '0;
            po_q <= '0;
        end else begin
            pv_q[1] <= sel.valid;
            ph_q[1] <= sel.is_host;
            po_q[1] <= sel.oob | sel_rw;
            for (int k = 2; k <= L; k++) begin
                pv_q[k] <= pv_q[k-1];
                ph_q[k] <= ph_q[k-1];
                po_q[k] <= po_q[k-1];
            end
        end
    end

    generate
        if (L == 1) begin : g_lat1
            assign last_data = ram_rdata;
        end else begin : g_latn
            logic [DATA_W-1:0] dq_q [2:L];
            // Extra register stages behind the RAM output to reach the configured latency
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 2; k <= L; k++) dq_q[k] <= '0;
                end else begin
                    dq_q[2] <= ram_rdata;
                    for (int k = 3; k <= L; k++) dq_q[k] <= dq_q[k-1];
                end
            end
            assign last_data = dq_q[L];
        end
    endgenerate

    assign done_k             = pv_q[L] & ~ph_q[L];
    assign done_h             = pv_q[L] & ph_q[L];
    assign stage_data         = po_q[L] ? '0 : last_data;
    assign avmm_0_rw_readdata = done_k ? stage_data : krd_q;
    assign host_readdata      = done_h ? stage_data : hrd_q;
    assign host_readdatavalid = done_h;
    assign oob_err            = oob_q;
    assign proto_err          = proto_q;

    // Read-data holding registers and sticky error flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            krd_q   <= '0;
            hrd_q   <= '0;
            oob_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            krd_q   <= avmm_0_rw_readdata;
            hrd_q   <= host_readdata;
            oob_q   <= oob_q | sel.oob;
            proto_q <= proto_q | (avmm_0_rw_read & avmm_0_rw_write);
        end
    end

`ifdef KERNEL_AVMM_MEM_PERF_EN
    logic [31:0] kr_cnt_q, kw_cnt_q, hs_cnt_q;

    // Saturating activity counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            kr_cnt_q <= '0;
            kw_cnt_q <= '0;
            hs_cnt_q <= '0;
        end else begin
            if (avmm_0_rw_read && kr_cnt_q != '1)  kr_cnt_q <= kr_cnt_q + 32'd1;
            if (avmm_0_rw_write && kw_cnt_q != '1) kw_cnt_q <= kw_cnt_q + 32'd1;
            if (host_waitrequest && hs_cnt_q != '1) hs_cnt_q <= hs_cnt_q + 32'd1;
        end
    end

    assign perf_kreads      = kr_cnt_q;
    assign perf_kwrites     = kw_cnt_q;
    assign perf_host_stalls = hs_cnt_q;
`endif

endmodule

// File: tb/tb_kernel_avmm_mem.sv
// tb/tb_kernel_avmm_mem.sv - scoreboard bench for kernel_avmm_mem with a word-level memory model
module tb_kernel_avmm_mem;

    localparam longint unsigned BASE  = 0;
    localparam longint unsigned DEPTH = 4096;
    localparam int              LAT   = 2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] k_addr = '0, k_wd = '0, h_addr = '0, h_wd = '0;
    logic [7:0]  k_be = '0, h_be = '0;
    logic        k_rd = 1'b0, k_wr = 1'b0, h_rd = 1'b0, h_wr = 1'b0;
    logic [63:0] k_rdata, h_rdata;
    logic        h_wait, h_valid, oob_err, proto_err;
`ifdef KERNEL_AVMM_MEM_PERF_EN
    logic [31:0] perf_kreads, perf_kwrites, perf_host_stalls;
`endif

    kernel_avmm_mem dut (
        .clock                (clock),
        .resetn               (resetn),
        .avmm_0_rw_address    (k_addr),
        .avmm_0_rw_byteenable (k_be),
        .avmm_0_rw_read       (k_rd),
        .avmm_0_rw_write      (k_wr),
        .avmm_0_rw_writedata  (k_wd),
        .avmm_0_rw_readdata   (k_rdata),
        .host_address         (h_addr),
        .host_byteenable      (h_be),
        .host_read            (h_rd),
        .host_write           (h_wr),
        .host_writedata       (h_wd),
        .host_waitrequest     (h_wait),
        .host_readdata        (h_rdata),
        .host_readdatavalid   (h_valid),
        .oob_err              (oob_err),
`ifdef KERNEL_AVMM_MEM_PERF_EN
        .perf_kreads          (perf_kreads),
        .perf_kwrites         (perf_kwrites),
        .perf_host_stalls     (perf_host_stalls),
`endif
        .proto_err            (proto_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    exp_t        kq[$];
    exp_t        hq[$];
    logic [63:0] mdl [longint unsigned];
    logic [63:0] khold = '0;
    logic        exp_wait = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) / 8) < DEPTH);
    endfunction

    function automatic longint unsigned word_of(input logic [63:0] a);
        return (a - BASE) / 8;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mread(input logic [63:0] a);
        if (!in_range(a)) return 64'd0;
        if (!mdl.exists(word_of(a))) return 64'd0;
        return mdl[word_of(a)];
    endfunction

    task automatic mwrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        if (in_range(a)) mdl[word_of(a)] = merge(mread(a), d, be);
    endtask

    // Drive one cycle of requests and record what the memory must answer
    task automatic step(input logic krd, input logic kwr, input logic [63:0] ka,
                        input logic [7:0] kb, input logic [63:0] kd,
                        input logic hrd, input logic hwr, input logic [63:0] ha,
                        input logic [7:0] hb, input logic [63:0] hd, output logic hacc);
        exp_t e;
        @(posedge clock); #1;
        k_rd = krd; k_wr = kwr; k_addr = ka; k_be = kb; k_wd = kd;
        h_rd = hrd; h_wr = hwr; h_addr = ha; h_be = hb; h_wd = hd;
        exp_wait = (hrd | hwr) & (krd | kwr);
        hacc = 1'b0;
        e.due = cyc + LAT;
        if (krd | kwr) begin
            if (kwr) mwrite(ka, kd, kb);
            if (krd) begin
                e.data = kwr ? 64'd0 : mread(ka);
                kq.push_back(e);
            end
        end else if (hrd | hwr) begin
            hacc = 1'b1;
            if (hwr) mwrite(ha, hd, hb);
            else begin
                e.data = mread(ha);
                hq.push_back(e);
            end
        end
    endtask

    task automatic kop(input logic krd, input logic kwr, input logic [63:0] a,
                       input logic [7:0] be, input logic [63:0] d);
        logic acc;
        step(krd, kwr, a, be, d, 1'b0, 1'b0, 64'd0, 8'h0, 64'd0, acc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) kop(1'b0, 1'b0, 64'd0, 8'h0, 64'd0);
    endtask

    // Scoreboard monitor: compares whatever the DUT presents against queued expectations
    always @(negedge clock) begin
        exp_t e;
        chk("host_waitrequest", {63'd0, h_wait}, {63'd0, exp_wait});
        if (kq.size() > 0 && kq[0].due <= cyc) begin
            e = kq.pop_front();
            khold = e.data;
            chk("kernel_readdata", k_rdata, e.data);
        end else begin
            chk("kernel_readdata_hold", k_rdata, khold);
        end
        if (hq.size() > 0 && hq[0].due <= cyc) begin
            e = hq.pop_front();
            chk("host_readdatavalid", {63'd0, h_valid}, 64'd1);
            chk("host_readdata", h_rdata, e.data);
        end else begin
            chk("host_readdatavalid_idle", {63'd0, h_valid}, 64'd0);
        end
    end

    initial begin
        logic        acc, hp_rd, hp_wr;
        logic [63:0] hp_a, hp_d;
        logic [7:0]  hp_b;
        logic        pend;

        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        @(posedge clock); #1;
        chk("reset_kernel_readdata", k_rdata, 64'd0);
        chk("reset_host_readdata", h_rdata, 64'd0);
        chk("reset_readdatavalid", {63'd0, h_valid}, 64'd0);
        chk("reset_waitrequest", {63'd0, h_wait}, 64'd0);
        chk("reset_oob_err", {63'd0, oob_err}, 64'd0);
        chk("reset_proto_err", {63'd0, proto_err}, 64'd0);

        kop(1'b0, 1'b1, 64'h40, 8'hFF, 64'h1122334455667788);
        kop(1'b1, 1'b0, 64'h40, 8'h00, 64'd0);
        idle(3);
        kop(1'b0, 1'b1, 64'h40, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        kop(1'b1, 1'b0, 64'h40, 8'h00, 64'd0);
        idle(3);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 64'h40, 8'h00, 64'd0, 1'b1, 1'b0, 64'h40, 8'hFF, 64'd0, acc);
            chk("host_held_by_kernel", {63'd0, acc}, 64'd0);
        end
        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0, 64'h40, 8'hFF, 64'd0, acc);
        idle(4);

        for (int w = 0; w < 16; w++)
            kop(1'b0, 1'b1, BASE + 64'(w) * 8, 8'hFF, {$urandom, $urandom});
        pend = 1'b0;
        hp_rd = 1'b0; hp_wr = 1'b0; hp_a = '0; hp_d = '0; hp_b = '0;
        for (int i = 0; i < 300; i++) begin
            int          r;
            logic [63:0] ka;
            r  = $urandom_range(0, 3);
            ka = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
            if (!pend && $urandom_range(0, 1) == 1) begin
                int hs;
                hs    = $urandom_range(0, 9);
                hp_rd = (hs <= 4) || (hs == 9);
                hp_wr = (hs >= 5);
                hp_a  = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
                hp_b  = 8'($urandom);
                hp_d  = {$urandom, $urandom};
                pend  = 1'b1;
            end
            step(r == 0, r == 1, ka, 8'($urandom), {$urandom, $urandom},
                 pend & hp_rd, pend & hp_wr, hp_a, hp_b, hp_d, acc);
            if (acc) pend = 1'b0;
        end
        idle(4);
        chk("random_oob_err", {63'd0, oob_err}, 64'd0);
        chk("random_proto_err", {63'd0, proto_err}, 64'd0);

        kop(1'b1, 1'b0, BASE + DEPTH * 8, 8'h00, 64'd0);
        idle(3);
        chk("oob_err_set", {63'd0, oob_err}, 64'd1);
        idle(3);
        chk("oob_err_sticky", {63'd0, oob_err}, 64'd1);

        kop(1'b1, 1'b1, 64'h48, 8'hFF, 64'hCAFEF00D_12345678);
        idle(3);
        chk("proto_err_set", {63'd0, proto_err}, 64'd1);
        kop(1'b1, 1'b0, 64'h48, 8'h00, 64'd0);
        idle(3);

        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0, 64'h48, 8'hFF, 64'd0, acc);
        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0, 64'h40, 8'hFF, 64'd0, acc);
        @(posedge clock); #1;
        h_rd = 1'b0; exp_wait = 1'b0;
        resetn = 1'b0;
        kq.delete();
        hq.delete();
        khold = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("midreset_kernel_readdata", k_rdata, 64'd0);
        chk("midreset_host_readdata", h_rdata, 64'd0);
        chk("midreset_readdatavalid", {63'd0, h_valid}, 64'd0);
        chk("midreset_oob_err", {63'd0, oob_err}, 64'd0);
        chk("midreset_proto_err", {63'd0, proto_err}, 64'd0);
        resetn = 1'b1;
        idle(3);
        kop(1'b1, 1'b0, 64'h40, 8'h00, 64'd0);
        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0, 64'h48, 8'hFF, 64'd0, acc);
        idle(5);
        chk("scoreboard_drained", 64'(kq.size() + hq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
